// File: rtl/logic_avalon_mm_command_fifo_if.sv
// Avalon-MM signal bundle shared by the upstream and downstream sides of the command FIFO.
interface logic_avalon_mm_if #(
  parameter int DATA_BYTES    = 4,
  parameter int ADDRESS_WIDTH = 1
);
  logic                       write;
  logic                       read;
  logic [ADDRESS_WIDTH-1:0]   address;
  logic [DATA_BYTES-1:0]      byteenable;
  logic [8*DATA_BYTES-1:0]    writedata;
  logic                       waitrequest;
  logic [1:0]                 response;
  logic [8*DATA_BYTES-1:0]    readdata;
  logic                       readdatavalid;
  logic                       writeresponsevalid;

  modport master (
    output write, read, address, byteenable, writedata,
    input  waitrequest, response, readdata, readdatavalid, writeresponsevalid
  );

  modport slave (
    input  write, read, address, byteenable, writedata,
    output waitrequest, response, readdata, readdatavalid, writeresponsevalid
  );
endinterface

// File: rtl/logic_avalon_mm_command_fifo.sv
// Registered Avalon-MM command FIFO with pass-through responses.
// Define LOGIC_AVALON_MM_COMMAND_FIFO_OUTSTANDING_LIMIT_EN to cap commands awaiting a response.
module logic_avalon_mm_command_fifo #(
  parameter int DATA_BYTES      = 4,
  parameter int ADDRESS_WIDTH   = 1,
  parameter int CAPACITY        = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic              aclk,
  input  logic              areset_n,
  logic_avalon_mm_if.slave  slave,
  logic_avalon_mm_if.master master
);
  localparam int DATA_WIDTH = 8 * DATA_BYTES;
  localparam int PTR_W      = (CAPACITY > 1) ? $clog2(CAPACITY) : 1;
  localparam int CNT_W      = $clog2(CAPACITY + 1);
  // An illegal configuration keeps the slave side stalled instead of misbehaving.
  localparam bit CFG_OK     = (CAPACITY >= 2) && (MAX_OUTSTANDING >= 1);

  typedef struct packed {
    logic                     write;
    logic                     read;
    logic [ADDRESS_WIDTH-1:0] address;
    logic [DATA_BYTES-1:0]    byteenable;
    logic [DATA_WIDTH-1:0]    writedata;
  } cmd_t;

  cmd_t             mem_q [CAPACITY];
  cmd_t             head;
  cmd_t             slave_cmd;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ready_q;
  logic             fifo_full, fifo_empty;
  logic             push, pop;
  logic             limit_hit;
  logic             wait_req;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(CAPACITY - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign fifo_full  = (count_q == CNT_W'(CAPACITY));
  assign fifo_empty = (count_q == '0);
  assign wait_req   = !ready_q || !CFG_OK || fifo_full || limit_hit;
  assign push       = (slave.write || slave.read) && !wait_req;

  assign slave_cmd = '{write:      slave.write,
                       read:       slave.read,
                       address:    slave.address,
                       byteenable: slave.byteenable,
                       writedata:  slave.writedata};

  assign head              = mem_q[rd_ptr_q];
  assign master.write      = !fifo_empty && head.write;
  assign master.read       = !fifo_empty && head.read;
  assign master.address    = head.address;
  assign master.byteenable = head.byteenable;
  assign master.writedata  = head.writedata;
  assign pop               = (master.write || master.read) && !master.waitrequest;

  assign slave.waitrequest        = wait_req;
  assign slave.response           = master.response;
  assign slave.readdata           = master.readdata;
  assign slave.readdatavalid      = master.readdatavalid;
  assign slave.writeresponsevalid = master.writeresponsevalid;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = next_ptr(wr_ptr_q);
    if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // ready_q holds the slave off during reset and releases it on the first edge after.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (push) mem_q[wr_ptr_q] <= slave_cmd;
  end

`ifdef LOGIC_AVALON_MM_COMMAND_FIFO_OUTSTANDING_LIMIT_EN
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [OUT_W-1:0] outstanding_q, outstanding_d;
  logic [OUT_W:0]   out_sum;
  logic [OUT_W:0]   out_dec;

  always_comb begin
    out_dec       = (OUT_W+1)'(master.readdatavalid) + (OUT_W+1)'(master.writeresponsevalid);
    out_sum       = {1'b0, outstanding_q} + (OUT_W+1)'(push);
    outstanding_d = '0;
    if (out_sum >= out_dec) outstanding_d = OUT_W'(out_sum - out_dec);
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) outstanding_q <= '0;
    else           outstanding_q <= outstanding_d;
  end

  assign limit_hit = (outstanding_q == OUT_W'(MAX_OUTSTANDING));

`ifndef SYNTHESIS
  // A response with nothing outstanding is clamped at zero but flagged here.
  assert property (@(posedge aclk) disable iff (!areset_n) out_sum >= out_dec);
`endif
`else
  assign limit_hit = 1'b0;
`endif
endmodule
